// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared widths, FSM encoding and grant decode for the slot arbiter
package rr_arb_pkg;
  localparam int NREQ   = 4;
  localparam int ID_W   = 2;
  localparam int SLOT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  function automatic logic [NREQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    id_to_onehot     = '0;
    id_to_onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_slot_arbiter_if.sv
// rtl/rr_slot_arbiter_if.sv - request/grant bundle between clients and the slot arbiter
interface rr_slot_arbiter_if;
  import rr_arb_pkg::*;

  logic [NREQ-1:0]   req_i;
  logic [NREQ-1:0]   release_i;
  logic [NREQ-1:0]   grant_o;
  logic [ID_W-1:0]   grant_id_o;
  logic              busy_o;
  logic [SLOT_W-1:0] slot_cnt_o;
  logic              expire_o;
  logic              clr_res_o;

  modport master (
    output req_i, release_i,
    input  grant_o, grant_id_o, busy_o, slot_cnt_o, expire_o, clr_res_o
  );

  modport slave (
    input  req_i, release_i,
    output grant_o, grant_id_o, busy_o, slot_cnt_o, expire_o, clr_res_o
  );
endinterface

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational round-robin pick: rotate by ptr, priority-encode, un-rotate
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);
  logic [2*NREQ-1:0] req_x2;
  logic [NREQ-1:0]   rot;
  logic [ID_W-1:0]   off;

  // rot[i] is the request of client (ptr+i) mod 4
  assign req_x2 = {req_i, req_i};
  assign rot    = req_x2[ptr_i +: NREQ];

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
  end

  assign id_o    = ptr_i + off;
  assign valid_o = |req_i;
endmodule

// File: rtl/rr_slot_arbiter.sv
// rtl/rr_slot_arbiter.sv - four-client round-robin arbiter with bounded slice and one-cycle clear gap
module rr_slot_arbiter
  import rr_arb_pkg::*;
#(
  parameter logic [SLOT_W-1:0] SLOT_LEN = 8'd4
) (
  input logic              clk,
  input logic              Reset,
  rr_slot_arbiter_if.slave bus
);
  if (SLOT_LEN == '0) begin : g_bad_slot_len
    $error("rr_slot_arbiter: SLOT_LEN must be in 1..255");
  end

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic              busy_q, busy_d;
  logic              expire_q, expire_d;
  logic              clr_res_q, clr_res_d;
  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;

  rr_pick_4 u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .id_o    (pick_id),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    slot_cnt_d = slot_cnt_q;
    busy_d     = busy_q;
    expire_d   = 1'b0;
    clr_res_d  = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_d    = GRANT;
          grant_d    = id_to_onehot(pick_id);
          grant_id_d = pick_id;
          ptr_d      = pick_id + ID_W'(1);
          slot_cnt_d = '0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        // Owner leaving wins over slice expiry, so expire stays low in that case
        if (!bus.req_i[grant_id_q] || bus.release_i[grant_id_q]) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          clr_res_d = 1'b1;
        end else if (slot_cnt_q == SLOT_LEN - SLOT_W'(1)) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          clr_res_d = 1'b1;
          expire_d  = 1'b1;
        end else begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      slot_cnt_q <= '0;
      busy_q     <= 1'b0;
      expire_q   <= 1'b0;
      clr_res_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      slot_cnt_q <= slot_cnt_d;
      busy_q     <= busy_d;
      expire_q   <= expire_d;
      clr_res_q  <= clr_res_d;
    end
  end

  assign bus.grant_o    = grant_q;
  assign bus.grant_id_o = grant_id_q;
  assign bus.busy_o     = busy_q;
  assign bus.slot_cnt_o = slot_cnt_q;
  assign bus.expire_o   = expire_q;
  assign bus.clr_res_o  = clr_res_q;
endmodule

// File: tb/tb_rr_slot_arbiter.sv
// tb/tb_rr_slot_arbiter.sv - scoreboard bench for rr_slot_arbiter with SLOT_LEN=4 and SLOT_LEN=1 builds
module tb_rr_slot_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_slot_arbiter_if bus4 ();
  rr_slot_arbiter_if bus1 ();

  rr_slot_arbiter #(.SLOT_LEN(8'd4)) dut4 (.clk(clk), .Reset(rst), .bus(bus4));
  rr_slot_arbiter #(.SLOT_LEN(8'd1)) dut1 (.clk(clk), .Reset(rst), .bus(bus1));

  typedef struct {
    int         st;
    logic [3:0] grant;
    logic [1:0] id;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic       expire;
    logic       clr;
    logic       busy;
  } mdl_t;

  mdl_t m4, m1;
  mdl_t q4[$];
  mdl_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic mdl_t model_step(input mdl_t m, input logic [3:0] rq, input logic [3:0] rl,
                                      input int slen, input logic r);
    mdl_t n;
    int   k;
    n        = m;
    n.expire = 1'b0;
    n.clr    = 1'b0;
    if (r) begin
      n.st = 0; n.grant = '0; n.id = '0; n.ptr = '0; n.cnt = '0; n.busy = 1'b0;
      return n;
    end
    if (m.st == 1) begin
      if (!rq[m.id] || rl[m.id]) begin
        n.st = 2; n.grant = '0; n.busy = 1'b0; n.clr = 1'b1;
      end else if (int'(m.cnt) == slen - 1) begin
        n.st = 2; n.grant = '0; n.busy = 1'b0; n.clr = 1'b1; n.expire = 1'b1;
      end else begin
        n.cnt = m.cnt + 8'd1;
      end
    end else begin
      n.st = 0; n.grant = '0; n.busy = 1'b0;
      for (int j = 0; j < 4; j++) begin
        k = (int'(m.ptr) + j) % 4;
        if (rq[k]) begin
          n.st = 1; n.grant = 4'(1 << k); n.id = 2'(k); n.ptr = 2'((k + 1) % 4);
          n.cnt = '0; n.busy = 1'b1;
          break;
        end
      end
    end
    return n;
  endfunction

  task automatic compare(input string who, input mdl_t e, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic [7:0] c, input logic ex, input logic cl);
    check({who, "_grant"},    32'(g),  32'(e.grant));
    check({who, "_grant_id"}, 32'(id), 32'(e.id));
    check({who, "_busy"},     32'(b),  32'(e.busy));
    check({who, "_slot_cnt"}, 32'(c),  32'(e.cnt));
    check({who, "_expire"},   32'(ex), 32'(e.expire));
    check({who, "_clr_res"},  32'(cl), 32'(e.clr));
  endtask

  task automatic step_cycle(input logic r, input logic [3:0] rq, input logic [3:0] rl, input logic [3:0] rq1);
    mdl_t e;
    @(negedge clk);
    rst            = r;
    bus4.req_i     = rq;
    bus4.release_i = rl;
    bus1.req_i     = rq1;
    bus1.release_i = 4'b0000;
    m4 = model_step(m4, rq, rl, 4, r);
    q4.push_back(m4);
    m1 = model_step(m1, rq1, 4'b0000, 1, r);
    q1.push_back(m1);
    @(posedge clk);
    #1;
    if (q4.size() == 0 || q1.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = q4.pop_front();
      compare("s4", e, bus4.grant_o, bus4.grant_id_o, bus4.busy_o, bus4.slot_cnt_o, bus4.expire_o, bus4.clr_res_o);
      e = q1.pop_front();
      compare("s1", e, bus1.grant_o, bus1.grant_id_o, bus1.busy_o, bus1.slot_cnt_o, bus1.expire_o, bus1.clr_res_o);
    end
  endtask

  logic [3:0] sl1_seq [8];

  initial begin
    m4 = '{st: 0, grant: 4'b0, id: 2'b0, ptr: 2'b0, cnt: 8'b0, expire: 1'b0, clr: 1'b0, busy: 1'b0};
    m1 = m4;
    bus4.req_i = '0; bus4.release_i = '0;
    bus1.req_i = '0; bus1.release_i = '0;

    // reset state
    step_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000);
    step_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000);
    check("reset_grant", 32'(bus4.grant_o), 32'd0);

    // single requester: 4-cycle slice, expiry gap, regrant to client 2
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b0, 4'b0100, 4'b0000, 4'b0000);
      if (i < 4) check("single_cnt", 32'(bus4.slot_cnt_o), 32'(i));
      if (i == 4) check("single_expire", 32'(bus4.expire_o), 32'd1);
      if (i == 5) check("single_regrant", 32'(bus4.grant_o), 32'b0100);
    end
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);

    // rotation from a fresh pointer
    step_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 25; i++) begin
      step_cycle(1'b0, 4'b1111, 4'b0000, 4'b0000);
      if (i % 5 == 0) check("rot_id", 32'(bus4.grant_id_o), 32'((i / 5) % 4));
      if (i % 5 == 4) check("rot_gap", 32'(bus4.grant_o), 32'd0);
    end
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);

    // early release by owner; non-owner release ignored
    step_cycle(1'b0, 4'b0010, 4'b0000, 4'b0000);
    step_cycle(1'b0, 4'b0010, 4'b0001, 4'b0000);
    check("nonowner_release", 32'(bus4.grant_o), 32'b0010);
    step_cycle(1'b0, 4'b0010, 4'b0010, 4'b0000);
    check("release_no_expire", 32'({bus4.clr_res_o, bus4.expire_o}), 32'b10);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);

    // request drop by client 3, then idle
    for (int i = 0; i < 3; i++) step_cycle(1'b0, 4'b1000, 4'b0000, 4'b0000);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);
    check("drop_idle_busy", 32'(bus4.busy_o), 32'd0);

    // release coinciding with final slice cycle
    for (int i = 0; i < 4; i++) step_cycle(1'b0, 4'b0001, 4'b0000, 4'b0000);
    step_cycle(1'b0, 4'b0001, 4'b0001, 4'b0000);
    check("release_at_last_expire", 32'(bus4.expire_o), 32'd0);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);

    // reset while client 3 holds slot_cnt=2
    for (int i = 0; i < 3; i++) step_cycle(1'b0, 4'b1000, 4'b0000, 4'b0000);
    step_cycle(1'b1, 4'b1000, 4'b0000, 4'b0000);
    check("midreset_cnt", 32'(bus4.slot_cnt_o), 32'd0);
    step_cycle(1'b0, 4'b1111, 4'b0000, 4'b0000);
    check("midreset_regrant", 32'(bus4.grant_o), 32'b0001);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);
    step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000);

    // random traffic on both builds
    for (int i = 0; i < 80; i++) begin
      step_cycle(1'b0, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 4'($urandom_range(0, 15)));
    end

    // SLOT_LEN=1 build alternation
    step_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000);
    sl1_seq[0] = 4'b0001; sl1_seq[1] = 4'b0000; sl1_seq[2] = 4'b0010; sl1_seq[3] = 4'b0000;
    sl1_seq[4] = 4'b0001; sl1_seq[5] = 4'b0000; sl1_seq[6] = 4'b0010; sl1_seq[7] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step_cycle(1'b0, 4'b0000, 4'b0000, 4'b0011);
      check("sl1_grant", 32'(bus1.grant_o), 32'(sl1_seq[i]));
      check("sl1_expire", 32'(bus1.expire_o), 32'(i % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rr_slot_arbiter.md
# rr_slot_arbiter

Four-requester round-robin arbiter with a bounded time slice. It shares one downstream resource, such as the 8-bit counter/decoder datapath, among four clients. Each grant is one-hot and lasts until the owner releases it, drops its request, or uses up `SLOT_LEN` cycles. A one-cycle dead gap separates consecutive grants so the resource can be cleared between owners.

## Interface
- `SLOT_LEN`, default 8'd4: maximum cycles per grant. Legal range is 1..255; the value 0 is an elaboration error.
- `clk` in 1: system clock; all logic is on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `req` in 4: request per client; bit k belongs to client k.
- `release` in 4: early release; only the bit of the current owner is honoured.
- `grant` out 4: one-hot grant, all zeros when no client owns the resource.
- `grant_id` out 2: index of the owner; holds its last value when `grant` is 0.
- `busy` out 1: high while in GRANT.
- `slot_cnt` out 8: number of cycles used by the current grant, counting from 0.
- `expire` out 1: one-cycle pulse, high during the GAP cycle that follows a time-slice expiry.
- `clr_res` out 1: high during every GAP cycle; drives the CLR of the shared resource.

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Reset values: state=IDLE, grant=0, grant_id=0, ptr=0, busy=0, slot_cnt=0, expire=0, clr_res=0.
- Arbitration, performed in IDLE or GAP when `|req` is true:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first set bit wins as k.
  - Next state is GRANT. grant=1<<k, grant_id=k, slot_cnt=0, ptr=(k+1) mod 4, so 3 wraps to 0.
- IDLE with `req==0`: stay in IDLE.
- GRANT, checked in priority order at each edge:
  - `!req[grant_id]` or `release[grant_id]` → GAP, expire=0.
  - Otherwise `slot_cnt==SLOT_LEN-1` → GAP, expire=1.
  - Otherwise stay in GRANT and increment slot_cnt.
- GAP (exactly 1 cycle): grant=0, busy=0, clr_res=1, slot_cnt holds its final value.
  - Exit to GRANT if `|req`, using the arbitration above, or to IDLE otherwise.
- Release and expiry in the same cycle: release wins and expire=0.
- `release` bits of non-owners are ignored in every state. `release` is ignored in IDLE and GAP.
- A client that has just been granted has the lowest priority at the next arbitration. This guarantees that no requester waits more than 3 other grants.
- Reset in the middle of a grant: the next state is IDLE with all outputs at their reset values. No expire pulse and no GAP cycle are produced.

## Timing
- Request latency: `req` sampled at edge t (IDLE) gives grant high after edge t, so the grant is visible in the cycle following the edge that sampled the request.
- A full time slice holds grant for exactly SLOT_LEN cycles (slot_cnt 0..SLOT_LEN-1).
- Between back-to-back owners the bus sees exactly 1 cycle of grant=0.
- With SLOT_LEN=1, every grant lasts 1 cycle and is followed by a GAP with expire=1.
- `expire` and `clr_res` are high in the same GAP cycle. Both are high for 1 cycle only.

## Structure
- Package `rr_arb_pkg`:
  - NREQ=4 and ID_W=2.
  - State encodings: IDLE=2'b00, GRANT=2'b01, GAP=2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
  - SLOT_W=8.
- Sub-module `rr_pick_4` is combinational. Inputs are req[3:0] and ptr[1:0]. Outputs are id[1:0] and valid. It performs the rotate, priority-encode and un-rotate. The top level owns the FSM, the pointer and the counters.
- The one-hot grant is a 2→4 decode of id, registered in the top level.

## Test plan
- **Single requester:** reset, then req=4'b0100 held with SLOT_LEN=4.
  - Required: grant=4'b0100 for 4 cycles with slot_cnt 0,1,2,3, then one GAP with expire=1 and clr_res=1, then a regrant to client 2.
- **Rotation:** req=4'b1111 held.
  - Required: grant_id sequence 0,1,2,3,0, each grant 4 cycles and separated by 1 GAP cycle.
  - Required: ptr wraps from 3 to 0.
- **Early release:** client 1 is granted; pulse release=4'b0010 at slot_cnt=1.
  - Required: GAP on the next cycle with expire=0; release=4'b0001 asserted during the grant has no effect.
- **Request drop and simultaneous events:**
  - Client 3 drops req at slot_cnt=2 → GAP, then IDLE when req=0.
  - release is asserted at slot_cnt=SLOT_LEN-1 → expire=0.
- **Reset mid-grant:** Reset=1 for 1 cycle while grant=4'b1000, slot_cnt=2.
  - Required: all outputs at their reset values on the next cycle, and the next arbitration with req=4'b1111 grants client 0.
- **SLOT_LEN=1 build:** req=4'b0011.
  - Required: grant alternates 0001, 0000, 0010, 0000, with expire=1 in every GAP cycle.
